// File: rtl/gf8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gf8_pkg
//  Description : Shared GF(2^3) definitions for the field divider: element
//                type, field polynomial x^3 + x^2 + 1, FSM state encoding,
//                inverse table and the iterative power-step count.
//  Revision    : 1.0 - initial release
// ============================================================================
package gf8_pkg;

  typedef logic [2:0] gf8_t;

  // Field polynomial x^3 + x^2 + 1.
  localparam logic [3:0] GF8_POLY = 4'b1101;

  // Divider FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    GF8_IDLE = 2'd0,
    GF8_POW  = 2'd1,
    GF8_MUL  = 2'd2,
    GF8_DONE = 2'd3
  } gf8_state_e;

  // Multiplicative inverse table, entry [d] = d^-1 (zero has no inverse; entry [0] holds 0).
  // Element order (high to low): 7->5, 6->2, 5->7, 4->3, 3->4, 2->6, 1->1, 0->0.
  localparam logic [7:0][2:0] GF8_INV_LUT = {3'd5, 3'd2, 3'd7, 3'd3,
                                             3'd4, 3'd6, 3'd1, 3'd0};

  // Multiplies needed after loading acc = D to reach D^6 = D^-1.
  localparam int GF8_POW_STEPS = 5;

  // Multiply by x and reduce modulo the field polynomial.
  function automatic gf8_t gf8_xtime(input gf8_t a);
    gf8_xtime = {a[1:0], 1'b0} ^ (a[2] ? GF8_POLY[2:0] : 3'b000);
  endfunction

endpackage : gf8_pkg
`default_nettype wire

// File: rtl/gf8_mul.sv
`default_nettype none
// ============================================================================
//  Module      : gf8_mul
//  Description : Purely combinational GF(2^3) multiplier. Carry-less 3x3
//                product, then the x^3 and x^4 terms are folded back using
//                the field polynomial.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf8_mul
  import gf8_pkg::*;
(
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [2:0] p
);

  // Reduced images of x^3 and x^4 (x^2+1 and x^2+x+1 for this polynomial).
  localparam gf8_t C_X3 = GF8_POLY[2:0];
  localparam gf8_t C_X4 = gf8_xtime(C_X3);

  logic [4:0] w_prod;

  // Carry-less product followed by reduction of the two overflow bits.
  always_comb begin
    w_prod = 5'b0;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) w_prod = w_prod ^ ({2'b00, a} << i);
    end
    p = w_prod[2:0]
      ^ (w_prod[3] ? C_X3 : 3'b000)
      ^ (w_prod[4] ? C_X4 : 3'b000);
  end

endmodule : gf8_mul
`default_nettype wire

// File: rtl/gf8_div.sv
`default_nettype none
// ============================================================================
//  Module      : gf8_div
//  Description : Sequential GF(2^3) divider, Q = N * D^-1, behind a
//                valid/ready handshake. D^-1 is built as D^6 by repeated
//                multiplication, or read from a table when GF8_DIV_LUT_EN
//                is defined. Division by zero returns Q = 0 and flags
//                div_by_zero.
//  Config      : GF8_DIV_LUT_EN - table inverse, 2-state path (no POW/cnt)
//  Revision    : 1.0 - initial release
// ============================================================================
module gf8_div
  import gf8_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] n_in,
  input  logic [2:0] d_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] q_out,
  output logic       div_by_zero
);

  gf8_state_e r_state;
  gf8_t       r_n;
  gf8_t       r_acc;
  gf8_t       r_q;
  logic       r_dbz;
  logic       r_out_valid;
  gf8_t       w_mul_a;
  gf8_t       w_mul_b;
  gf8_t       w_mul_p;

`ifdef GF8_DIV_LUT_EN
  // Only the final N * D^-1 product needs the multiplier.
  assign w_mul_a = r_n;
  assign w_mul_b = r_acc;
`else
  gf8_t       r_d;
  logic [2:0] r_cnt;

  // Shared multiplier: acc*D while raising to the power, N*acc for the quotient.
  assign w_mul_a = (r_state == GF8_MUL) ? r_n   : r_acc;
  assign w_mul_b = (r_state == GF8_MUL) ? r_acc : r_d;

  // Power-step counter and divisor copy, used only by the iterative path.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_d   <= 3'b000;
      r_cnt <= 3'b000;
    end else if (r_state == GF8_IDLE && in_valid) begin
      r_d   <= d_in;
      r_cnt <= 3'b000;
    end else if (r_state == GF8_POW) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end
`endif

  gf8_mul u_mul (
    .a (w_mul_a),
    .b (w_mul_b),
    .p (w_mul_p)
  );

  // Main control FSM and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= GF8_IDLE;
      r_n         <= 3'b000;
      r_acc       <= 3'b000;
      r_q         <= 3'b000;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        GF8_IDLE: begin
          if (in_valid) begin
            r_n   <= n_in;
            r_dbz <= (d_in == 3'b000);
`ifdef GF8_DIV_LUT_EN
            r_acc <= GF8_INV_LUT[d_in];
`else
            r_acc <= d_in;
`endif
            if (d_in == 3'b000) begin
              // Zero divisor: skip straight to the result.
              r_q         <= 3'b000;
              r_out_valid <= 1'b1;
              r_state     <= GF8_DONE;
            end else begin
`ifdef GF8_DIV_LUT_EN
              r_state <= GF8_MUL;
`else
              r_state <= GF8_POW;
`endif
            end
          end
        end
`ifdef GF8_DIV_LUT_EN
`else
        GF8_POW: begin
          r_acc <= w_mul_p;
          if (r_cnt == 3'(GF8_POW_STEPS - 1)) r_state <= GF8_MUL;
        end
`endif
        GF8_MUL: begin
          r_q         <= w_mul_p;
          r_out_valid <= 1'b1;
          r_state     <= GF8_DONE;
        end
        GF8_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= GF8_IDLE;
          end
        end
        default: r_state <= GF8_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == GF8_IDLE);
  assign out_valid   = r_out_valid;
  assign q_out       = r_q;
  assign div_by_zero = r_dbz;

endmodule : gf8_div
`default_nettype wire

// File: tb/tb_gf8_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf8_div
//  Description : Self-checking bench for gf8_div. Reference arithmetic is
//                polynomial multiplication mod x^3+x^2+1 with inverses
//                found by search.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf8_div;

  logic       clk;
  logic       n_rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] n_in;
  logic [2:0] d_in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] q_out;
  logic       div_by_zero;

  int checks;
  int failures;

  gf8_div dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .n_in        (n_in),
    .d_in        (d_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q_out       (q_out),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef GF8_DIV_LUT_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 6;
`endif

  // Field product: schoolbook polynomial multiply, then remainder mod 0b1101.
  function automatic int ref_mul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 3; i++) if ((b >> i) & 1) p = p ^ (a << i);
    for (int i = 4; i >= 3; i--) if ((p >> i) & 1) p = p ^ (13 << (i - 3));
    return p & 7;
  endfunction

  // Quotient via brute-force search for the inverse of d.
  function automatic int ref_div(input int n, input int d);
    int inv;
    inv = 0;
    for (int x = 1; x < 8; x++) if (ref_mul(x, d) == 1) inv = x;
    return (d == 0) ? 0 : ref_mul(n, inv);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction; out_ready withheld for 'hold' cycles once the result is up.
  task automatic run_op(input int n, input int d, input int hold, input string tag,
                        output int q, output int dbz);
    int t;
    int lat;
    int q0;
    int z0;
    t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    chk({tag, "_ready"}, int'(in_ready), 1);
    n_in = 3'(n); d_in = 3'(d); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    chk({tag, "_lat"}, lat, (d == 0) ? 0 : EXP_LAT);
    q0 = int'(q_out); z0 = int'(div_by_zero);
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0]; n_in = 3'($urandom); d_in = 3'($urandom);
      step();
      chk({tag, "_hold_q"}, int'(q_out), q0);
      chk({tag, "_hold_ovld"}, int'(out_valid), 1);
      chk({tag, "_hold_rdy"}, int'(in_ready), 0);
    end
    in_valid = 1'b0;
    q = q0; dbz = z0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_rel_ovld"}, int'(out_valid), 0);
    chk({tag, "_rel_rdy"}, int'(in_ready), 1);
  endtask

  initial begin
    int q;
    int z;
    checks = 0; failures = 0;
    in_valid = 1'b0; n_in = 3'd0; d_in = 3'd0; out_ready = 1'b0;
    n_rst = 1'b0;
    step(); step();
    chk("rst_ovld", int'(out_valid), 0);
    chk("rst_rdy", int'(in_ready), 1);
    chk("rst_q", int'(q_out), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    n_rst = 1'b1;
    step();

    // Directed cases.
    run_op(1, 2, 0, "basic", q, z);
    chk("basic_q", q, 6); chk("basic_dbz", z, 0);
    run_op(3, 5, 1, "n3d5", q, z);
    chk("n3d5_q", q, 4); chk("n3d5_dbz", z, 0);
    run_op(5, 5, 0, "n5d5", q, z);
    chk("n5d5_q", q, 1);
    run_op(0, 7, 0, "n0d7", q, z);
    chk("n0d7_q", q, 0); chk("n0d7_dbz", z, 0);
    run_op(6, 0, 0, "dbz", q, z);
    chk("dbz_q", q, 0); chk("dbz_flag", z, 1);

    // Backpressure: result held 10 cycles while in_valid pulses are ignored.
    run_op(7, 3, 10, "bp", q, z);
    chk("bp_q", q, ref_div(7, 3)); chk("bp_dbz", z, 0);

    // Leave q_out nonzero, then reset in the middle of a computation.
    run_op(1, 2, 0, "prerst", q, z);
    n_in = 3'd3; d_in = 3'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_rst = 1'b0;
    #2;
    chk("midrst_ovld", int'(out_valid), 0);
    chk("midrst_rdy", int'(in_ready), 1);
    chk("midrst_q", int'(q_out), 0);
    chk("midrst_dbz", int'(div_by_zero), 0);
    step();
    n_rst = 1'b1;
    step();
    chk("postrst_rdy", int'(in_ready), 1);

    // All operand pairs, shuffled order, random backpressure.
    begin
      int order[64];
      int tmp;
      int j;
      for (int i = 0; i < 64; i++) order[i] = i;
      for (int i = 63; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < 64; i++) begin
        int n;
        int d;
        n = order[i] >> 3; d = order[i] & 7;
        run_op(n, d, int'($urandom_range(0, 3)), "exh", q, z);
        if (d != 0) chk("exh_back", ref_mul(q, d), n);
        chk("exh_q", q, ref_div(n, d));
        chk("exh_dbz", z, (d == 0) ? 1 : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gf8_div
`default_nettype wire
